// File: rtl/adc_spi_responder.sv
// adc_spi_responder: emulates the dual-chip serial APD ADC (temp on CS1, HV on CS2,
// shared SDA). Every pin is oversampled in the system clock domain. A frame presents
// LEAD_ZEROS zeros, the DATA_W-bit code (MSB first), then trailing zeros. SDA advances
// on each synchronized SCLK falling edge.
module adc_spi_responder #(
  parameter int unsigned DATA_W      = 10,
  parameter int unsigned LEAD_ZEROS  = 3,
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
  input  logic              i_clk_50m,
  input  logic              i_rst,
  input  logic              i_adc_sclk,
  input  logic              i_adc_cs1,
  input  logic              i_adc_cs2,
  output logic              o_adc_sda,
  output logic              o_adc_sda_oe,
  input  logic [DATA_W-1:0] i_ch1_value,
  input  logic [DATA_W-1:0] i_ch2_value,
  output logic              o_frame_done,
  output logic              o_frame_ch,
  output logic              o_frame_err,
  output logic [15:0]       o_frame_cnt
);

  localparam int unsigned TrailZeros = FRAME_BITS - LEAD_ZEROS - DATA_W;
  localparam int unsigned CntW       = $clog2(FRAME_BITS + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(FRAME_BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {StIdle, StShift, StConflict} state_e;

  // Input synchronizers plus one delayed copy for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs1_sync_q, cs2_sync_q;
  logic                   sclk_prev_q, cs1_prev_q, cs2_prev_q;
  logic                   sclk_s, cs1_s, cs2_s;
  logic                   sclk_fall, cs1_fall, cs2_fall, cs1_rise, cs2_rise;

  // Frame state
  state_e                  state_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [CntW-1:0]         bit_cnt_q;
  logic                    sda_q, oe_q, done_q, err_q, ch_q;
  logic [15:0]             frame_cnt_q;

  // Frame images built from the live channel codes; only latched at CS fall
  logic [FRAME_BITS-1:0]   ch1_ext, ch2_ext, load_ch1, load_ch2;
  logic                    active_rise, other_fall;

  // Synchronizer chains, preset to the idle-high level of SCLK and both CS lines
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync_q <= '1;
      cs1_sync_q  <= '1;
      cs2_sync_q  <= '1;
      sclk_prev_q <= 1'b1;
      cs1_prev_q  <= 1'b1;
      cs2_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_adc_sclk};
      cs1_sync_q  <= {cs1_sync_q[SYNC_STAGES-2:0], i_adc_cs1};
      cs2_sync_q  <= {cs2_sync_q[SYNC_STAGES-2:0], i_adc_cs2};
      sclk_prev_q <= sclk_s;
      cs1_prev_q  <= cs1_s;
      cs2_prev_q  <= cs2_s;
    end
  end

  // Edge detection on the synchronized levels
  always_comb begin
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    cs1_s     = cs1_sync_q[SYNC_STAGES-1];
    cs2_s     = cs2_sync_q[SYNC_STAGES-1];
    sclk_fall = sclk_prev_q & ~sclk_s;
    cs1_fall  = cs1_prev_q & ~cs1_s;
    cs2_fall  = cs2_prev_q & ~cs2_s;
    cs1_rise  = ~cs1_prev_q & cs1_s;
    cs2_rise  = ~cs2_prev_q & cs2_s;
    // Active CS is the one selected at frame start; the other one is an intruder
    active_rise = ch_q ? cs2_rise : cs1_rise;
    other_fall  = ch_q ? cs1_fall : cs2_fall;
  end

  // Frame images: {lead zeros, code, trailing zeros}
  always_comb begin
    ch1_ext                = '0;
    ch2_ext                = '0;
    ch1_ext[DATA_W-1:0]    = i_ch1_value;
    ch2_ext[DATA_W-1:0]    = i_ch2_value;
    load_ch1               = ch1_ext << TrailZeros;
    load_ch2               = ch2_ext << TrailZeros;
  end

  // Responder FSM with registered outputs
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      sda_q       <= 1'b0;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ch_q        <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!cs1_s && !cs2_s) begin
            state_q <= StConflict;
            oe_q    <= 1'b0;
            sda_q   <= 1'b0;
          end else if (cs1_fall || cs2_fall) begin
            shift_q   <= cs1_fall ? load_ch1 : load_ch2;
            sda_q     <= cs1_fall ? load_ch1[FRAME_BITS-1] : load_ch2[FRAME_BITS-1];
            ch_q      <= ~cs1_fall;
            bit_cnt_q <= '0;
            oe_q      <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          // CS rise takes priority over an SCLK edge in the same cycle
          if (active_rise) begin
            if (bit_cnt_q >= CntLast) begin
              done_q      <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
              err_q <= 1'b1;
            end
            oe_q    <= 1'b0;
            sda_q   <= 1'b0;
            state_q <= StIdle;
          end else if (other_fall) begin
            err_q   <= 1'b1;
            oe_q    <= 1'b0;
            sda_q   <= 1'b0;
            state_q <= StConflict;
          end else if (sclk_fall) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
            sda_q   <= shift_q[FRAME_BITS-2];
            if (bit_cnt_q != CntMax) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        StConflict: begin
          oe_q  <= 1'b0;
          sda_q <= 1'b0;
          if (cs1_s && cs2_s) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          oe_q    <= 1'b0;
          sda_q   <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping
  always_comb begin
    o_adc_sda    = sda_q;
    o_adc_sda_oe = oe_q;
    o_frame_done = done_q;
    o_frame_err  = err_q;
    o_frame_ch   = ch_q;
    o_frame_cnt  = frame_cnt_q;
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: 50 MHz system clock, 5 MHz SCLK frames.
// SDA is sampled during the SCLK high phase just before each falling edge.
module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, cs1, cs2;
  logic        sda, sda_oe;
  logic [9:0]  ch1_val, ch2_val;
  logic        done, frame_ch, err;
  logic [15:0] frame_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  int          done_pulses = 0;
  int          err_pulses = 0;
  int          both_pulses = 0;
  logic        last_ch = 1'b0;
  logic [15:0] word;
  logic        oe_low_seen;
  int          d0, e0;

  adc_spi_responder dut (
    .i_clk_50m   (clk),
    .i_rst       (rst),
    .i_adc_sclk  (sclk),
    .i_adc_cs1   (cs1),
    .i_adc_cs2   (cs2),
    .o_adc_sda   (sda),
    .o_adc_sda_oe(sda_oe),
    .i_ch1_value (ch1_val),
    .i_ch2_value (ch2_val),
    .o_frame_done(done),
    .o_frame_ch  (frame_ch),
    .o_frame_err (err),
    .o_frame_cnt (frame_cnt)
  );

  always #10 clk = ~clk;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (done) begin
      done_pulses <= done_pulses + 1;
      last_ch     <= frame_ch;
    end
    if (err) err_pulses <= err_pulses + 1;
    if (done && err) both_pulses <= both_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clock n SCLK cycles, shifting the pre-fall SDA value into word
  task automatic clock_bits(input int n);
    for (int i = 0; i < n; i++) begin
      word = {word[14:0], sda};
      if (!sda_oe) oe_low_seen = 1'b1;
      sclk = 1'b0;
      #100;
      sclk = 1'b1;
      #100;
    end
  endtask

  task automatic start_frame(input logic ch);
    word        = 16'h0;
    oe_low_seen = 1'b0;
    d0          = done_pulses;
    e0          = err_pulses;
    if (ch) cs2 = 1'b0;
    else    cs1 = 1'b0;
    #200;
  endtask

  task automatic end_frame(input logic ch);
    if (ch) cs2 = 1'b1;
    else    cs1 = 1'b1;
    #200;
  endtask

  initial begin
    rst     = 1'b1;
    sclk    = 1'b1;
    cs1     = 1'b1;
    cs2     = 1'b1;
    ch1_val = 10'h2A5;
    ch2_val = 10'h3FF;
    @(negedge clk);
    #100;
    check("rst_sda", sda, 1'b0);
    check("rst_oe", sda_oe, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ch", frame_ch, 1'b0);
    check("rst_cnt", frame_cnt, 16'd0);
    rst = 1'b0;
    #200;

    // CS1 frame, 0x2A5
    start_frame(1'b0);
    clock_bits(16);
    end_frame(1'b0);
    check("ch1_word", word, 16'h1528);
    check("ch1_oe_held", oe_low_seen, 1'b0);
    check("ch1_done", done_pulses - d0, 1);
    check("ch1_noerr", err_pulses - e0, 0);
    check("ch1_ch", last_ch, 1'b0);
    check("ch1_cnt", frame_cnt, 16'd1);
    check("ch1_oe_off", sda_oe, 1'b0);

    // CS2 frame, 0x3FF
    start_frame(1'b1);
    clock_bits(16);
    end_frame(1'b1);
    check("ch2_word", word, 16'h1FF8);
    check("ch2_done", done_pulses - d0, 1);
    check("ch2_ch", last_ch, 1'b1);
    check("ch2_cnt", frame_cnt, 16'd2);

    // Short CS1 frame, 8 SCLK
    start_frame(1'b0);
    clock_bits(8);
    end_frame(1'b0);
    check("short_word", word, 16'h0015);
    check("short_err", err_pulses - e0, 1);
    check("short_nodone", done_pulses - d0, 0);
    check("short_cnt", frame_cnt, 16'd2);
    check("short_oe", sda_oe, 1'b0);

    // CS2 intrudes on a CS1 frame
    start_frame(1'b0);
    clock_bits(4);
    check("conf_oe_before", sda_oe, 1'b1);
    cs2 = 1'b0;
    #200;
    check("conf_err", err_pulses - e0, 1);
    check("conf_oe", sda_oe, 1'b0);
    cs2 = 1'b1;
    #200;
    check("conf_oe_cs1_low", sda_oe, 1'b0);
    cs1 = 1'b1;
    #200;
    check("conf_nodone", done_pulses - d0, 0);
    check("conf_cnt", frame_cnt, 16'd2);
    start_frame(1'b0);
    clock_bits(16);
    end_frame(1'b0);
    check("after_conf_word", word, 16'h1528);
    check("after_conf_done", done_pulses - d0, 1);
    check("after_conf_cnt", frame_cnt, 16'd3);

    // Code changes mid-frame
    ch1_val = 10'h100;
    start_frame(1'b0);
    clock_bits(5);
    ch1_val = 10'h0FF;
    clock_bits(11);
    end_frame(1'b0);
    check("mid_word", word, 16'h0800);
    check("mid_cnt", frame_cnt, 16'd4);
    start_frame(1'b0);
    clock_bits(16);
    end_frame(1'b0);
    check("next_word", word, 16'h07F8);
    check("next_cnt", frame_cnt, 16'd5);

    // Reset in the middle of a frame
    start_frame(1'b0);
    clock_bits(4);
    check("prerst_oe", sda_oe, 1'b1);
    #40;
    rst = 1'b1;
    #1;
    check("midrst_oe", sda_oe, 1'b0);
    check("midrst_sda", sda, 1'b0);
    check("midrst_cnt", frame_cnt, 16'd0);
    check("midrst_done", done, 1'b0);
    check("midrst_err", err, 1'b0);
    #19;
    cs1 = 1'b1;
    #40;
    rst = 1'b0;
    #100;
    start_frame(1'b0);
    clock_bits(16);
    end_frame(1'b0);
    check("postrst_word", word, 16'h07F8);
    check("postrst_cnt", frame_cnt, 16'd1);
    check("done_err_exclusive", both_pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
